// File: rtl/matmul_controller_pkg.sv
// rtl/matmul_controller_pkg.sv - shared encodings for the matrix-multiply sequencer
package matmul_controller_pkg;

    // Register-file access type (out_rf_type)
    localparam logic [1:0] TYPE_CELL = 2'b00;
    localparam logic [1:0] TYPE_ROW  = 2'b01;
    localparam logic [1:0] TYPE_COL  = 2'b10;

    // Register-file matrix select (out_rf_select); 2'b11 is never driven
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ROW  = 3'd1,
        S_RD_COL  = 3'd2,
        S_LAT_COL = 3'd3,
        S_MAC     = 3'd4,
        S_WR      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/matmul_controller_mac_unit.sv
// rtl/matmul_controller_mac_unit.sv - multiply-accumulate datapath, wraps modulo 2^cell_width
module matmul_controller_mac_unit #(
    parameter int cell_width = 32
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_clr,
    input  logic                  in_en,
    input  logic [cell_width-1:0] in_a,
    input  logic [cell_width-1:0] in_b,
    output logic [cell_width-1:0] out_acc
);

    logic [cell_width-1:0] acc_q;
    logic [cell_width-1:0] acc_d;
    logic [cell_width-1:0] prod;

    // Low half of the product only; the sum is identical for signed and unsigned cells
    always_comb begin
        prod  = in_a * in_b;
        acc_d = acc_q;
        if (in_clr) begin
            acc_d = '0;
        end else if (in_en) begin
            acc_d = acc_q + prod;
        end
    end

    // Accumulator register
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_acc = acc_q;

endmodule

// File: rtl/matmul_controller.sv
// rtl/matmul_controller.sv - sequencer computing C = A x B over the coprocessor register file
module matmul_controller
    import matmul_controller_pkg::*;
#(
    parameter int size          = 10,
    parameter int address_width = $clog2(size * size),
    parameter int cell_width    = 32,
    parameter int width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    input  logic [width-1:0]         in_rf_data,
    output logic [address_width-1:0] out_rf_address,
    output logic [width-1:0]         out_rf_data,
    output logic [1:0]               out_rf_type,
    output logic [1:0]               out_rf_select,
    output logic                     out_rf_read_en,
    output logic                     out_rf_write_en,
    output logic                     out_busy,
    output logic                     out_done
);

    localparam logic [address_width-1:0] LAST = address_width'(size - 1);

    state_t                    state_q, state_d;
    logic [address_width-1:0]  i_q, i_d;
    logic [address_width-1:0]  j_q, j_d;
    logic [address_width-1:0]  k_q, k_d;
    logic [width-1:0]          row_buf_q, row_buf_d;
    logic [width-1:0]          col_buf_q, col_buf_d;
    logic                      row_pending_q, row_pending_d;

    logic                      mac_clr;
    logic                      mac_en;
    logic [cell_width-1:0]     row_cell;
    logic [cell_width-1:0]     col_cell;
    logic [cell_width-1:0]     acc;

    // Select cell k of the buffered row and column as the MAC operands
    always_comb begin
        row_cell = '0;
        col_cell = '0;
        for (int n = 0; n < size; n++) begin
            if (k_q == address_width'(n)) begin
                row_cell = row_buf_q[n*cell_width +: cell_width];
                col_cell = col_buf_q[n*cell_width +: cell_width];
            end
        end
    end

    matmul_controller_mac_unit #(
        .cell_width (cell_width)
    ) u_mac (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .in_clr   (mac_clr),
        .in_en    (mac_en),
        .in_a     (row_cell),
        .in_b     (col_cell),
        .out_acc  (acc)
    );

    // Next-state, counter updates and Moore outputs decoded from state and counters
    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        k_d             = k_q;
        row_buf_d       = row_buf_q;
        col_buf_d       = col_buf_q;
        row_pending_d   = row_pending_q;
        mac_clr         = 1'b0;
        mac_en          = 1'b0;
        out_rf_address  = '0;
        out_rf_data     = '0;
        out_rf_type     = TYPE_CELL;
        out_rf_select   = SEL_A;
        out_rf_read_en  = 1'b0;
        out_rf_write_en = 1'b0;
        out_busy        = 1'b0;
        out_done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RD_ROW;
                end
            end
            S_RD_ROW: begin
                out_busy       = 1'b1;
                out_rf_address = address_width'(i_q * size);
                out_rf_type    = TYPE_ROW;
                out_rf_select  = SEL_A;
                out_rf_read_en = 1'b1;
                row_pending_d  = 1'b1;
                state_d        = S_RD_COL;
            end
            S_RD_COL: begin
                // Row data requested last cycle arrives now; later columns reuse row_buf
                out_busy       = 1'b1;
                out_rf_address = j_q;
                out_rf_type    = TYPE_COL;
                out_rf_select  = SEL_B;
                out_rf_read_en = 1'b1;
                if (row_pending_q) begin
                    row_buf_d     = in_rf_data;
                    row_pending_d = 1'b0;
                end
                state_d = S_LAT_COL;
            end
            S_LAT_COL: begin
                out_busy  = 1'b1;
                col_buf_d = in_rf_data;
                mac_clr   = 1'b1;
                k_d       = '0;
                state_d   = S_MAC;
            end
            S_MAC: begin
                out_busy = 1'b1;
                mac_en   = 1'b1;
                if (k_q == LAST) begin
                    state_d = S_WR;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WR: begin
                out_busy        = 1'b1;
                out_rf_address  = address_width'(i_q * size + j_q);
                out_rf_type     = TYPE_CELL;
                out_rf_select   = SEL_C;
                out_rf_write_en = 1'b1;
                out_rf_data     = width'(acc);
                if (j_q != LAST) begin
                    j_d     = j_q + 1'b1;
                    state_d = S_RD_COL;
                end else if (i_q != LAST) begin
                    j_d     = '0;
                    i_d     = i_q + 1'b1;
                    state_d = S_RD_ROW;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and operand buffers
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q       <= S_IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            row_buf_q     <= '0;
            col_buf_q     <= '0;
            row_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            row_buf_q     <= row_buf_d;
            col_buf_q     <= col_buf_d;
            row_pending_q <= row_pending_d;
        end
    end

endmodule

// File: tb/tb_matmul_controller.sv
// tb/tb_matmul_controller.sv - self-checking bench: size-2 and size-3 sequencers on model register files
module tb_matmul_controller;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;

    // size = 2 instance
    logic        start2;
    logic [63:0] rd2;
    logic [1:0]  addr2;
    logic [63:0] wdata2;
    logic [1:0]  typ2, sel2;
    logic        re2, we2, busy2, done2;

    // size = 3 instance
    logic        start3;
    logic [95:0] rd3;
    logic [3:0]  addr3;
    logic [95:0] wdata3;
    logic [1:0]  typ3, sel3;
    logic        re3, we3, busy3, done3;

    // Register-file storage: index = select*size*size + row*size + col
    logic [31:0] mem2 [0:11];
    logic [31:0] mem3 [0:26];

    logic        hw2_en, hw3_en;
    int          hw2_idx, hw3_idx;
    logic [31:0] hw2_data, hw3_data;

    logic [31:0] ma [0:8];
    logic [31:0] mb [0:8];
    logic [31:0] mc_exp [0:8];

    int n_checks = 0;
    int n_fail   = 0;

    matmul_controller #(.size(2)) u_dut2 (
        .in_clk          (clk),
        .in_reset        (rst_n),
        .in_start        (start2),
        .in_rf_data      (rd2),
        .out_rf_address  (addr2),
        .out_rf_data     (wdata2),
        .out_rf_type     (typ2),
        .out_rf_select   (sel2),
        .out_rf_read_en  (re2),
        .out_rf_write_en (we2),
        .out_busy        (busy2),
        .out_done        (done2)
    );

    matmul_controller #(.size(3)) u_dut3 (
        .in_clk          (clk),
        .in_reset        (rst_n),
        .in_start        (start3),
        .in_rf_data      (rd3),
        .out_rf_address  (addr3),
        .out_rf_data     (wdata3),
        .out_rf_type     (typ3),
        .out_rf_select   (sel3),
        .out_rf_read_en  (re3),
        .out_rf_write_en (we3),
        .out_busy        (busy3),
        .out_done        (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register file, size 2: one-cycle read latency, cell writes
    always @(posedge clk) begin
        if (hw2_en) mem2[hw2_idx] <= hw2_data;
        if (we2 && typ2 == 2'b00) mem2[int'(sel2)*4 + int'(addr2)] <= wdata2[31:0];
        if (re2) begin
            for (int k = 0; k < 2; k++) begin
                if (typ2 == 2'b01) rd2[k*32 +: 32] <= mem2[int'(sel2)*4 + int'(addr2) + k];
                else               rd2[k*32 +: 32] <= mem2[int'(sel2)*4 + k*2 + int'(addr2)];
            end
        end
    end

    // Register file, size 3
    always @(posedge clk) begin
        if (hw3_en) mem3[hw3_idx] <= hw3_data;
        if (we3 && typ3 == 2'b00) mem3[int'(sel3)*9 + int'(addr3)] <= wdata3[31:0];
        if (re3) begin
            for (int k = 0; k < 3; k++) begin
                if (typ3 == 2'b01) rd3[k*32 +: 32] <= mem3[int'(sel3)*9 + int'(addr3) + k];
                else               rd3[k*32 +: 32] <= mem3[int'(sel3)*9 + k*3 + int'(addr3)];
            end
        end
    end

    // Strobe rules checked every cycle on both instances
    always @(negedge clk) begin
        chk("strobe2_rw", {63'd0, re2 & we2}, 64'd0);
        chk("strobe2_sel", {62'd0, sel2}, (sel2 == 2'b11) ? 64'd0 : {62'd0, sel2});
        chk("strobe2_colsel", {63'd0, (typ2 == 2'b10) && (sel2 != 2'b01)}, 64'd0);
        chk("strobe3_rw", {63'd0, re3 & we3}, 64'd0);
        chk("strobe3_sel", {62'd0, sel3}, (sel3 == 2'b11) ? 64'd0 : {62'd0, sel3});
        chk("strobe3_colsel", {63'd0, (typ3 == 2'b10) && (sel3 != 2'b01)}, 64'd0);
        if (we2) chk("wdata2_upper", {32'd0, wdata2[63:32]}, 64'd0);
        if (we3) chk("wdata3_upper", wdata3[95:32], 64'd0);
    end

    function automatic logic [31:0] rdmem(input int sz, input int sel, input int idx);
        if (sz == 2) return mem2[sel*4 + idx];
        return mem3[sel*9 + idx];
    endfunction

    function automatic int n_cycles(input int sz);
        return sz*sz*(sz+3) + sz;
    endfunction

    // Reference: plain matrix product, 32-bit wrapping
    task automatic model(input int sz);
        for (int i = 0; i < sz; i++) begin
            for (int j = 0; j < sz; j++) begin
                logic [31:0] s;
                s = 32'd0;
                for (int k = 0; k < sz; k++) s = s + ma[i*sz+k] * mb[k*sz+j];
                mc_exp[i*sz+j] = s;
            end
        end
    endtask

    task automatic hw(input int sz, input int idx, input logic [31:0] d);
        @(negedge clk);
        if (sz == 2) begin hw2_en = 1'b1; hw2_idx = idx; hw2_data = d; end
        else         begin hw3_en = 1'b1; hw3_idx = idx; hw3_data = d; end
        @(posedge clk);
        #1;
        hw2_en = 1'b0;
        hw3_en = 1'b0;
    endtask

    // Preload A and B from ma/mb; fill C with a sentinel
    task automatic load(input int sz);
        for (int n = 0; n < sz*sz; n++) begin
            hw(sz, n, ma[n]);
            hw(sz, sz*sz + n, mb[n]);
            hw(sz, 2*sz*sz + n, SENT);
        end
    endtask

    task automatic set_start(input int sz, input logic v);
        if (sz == 2) start2 = v;
        else         start3 = v;
    endtask

    // Start a run and observe a bounded window; optional extra start pulses in cycles pa/pb
    task automatic run(input int sz, input int pa, input int pb,
                       output int done_cyc, output int busy_cnt, output int done_cnt);
        int win;
        win      = n_cycles(sz) + 30;
        done_cyc = -1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        set_start(sz, 1'b1);
        @(posedge clk);
        #1;
        set_start(sz, 1'b0);
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            set_start(sz, (c == pa) || (c == pb));
            if ((sz == 2) ? busy2 : busy3) busy_cnt++;
            if ((sz == 2) ? done2 : done3) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        set_start(sz, 1'b0);
    endtask

    task automatic check_run(input string tag, input int sz, input int done_cyc,
                             input int busy_cnt, input int done_cnt);
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(n_cycles(sz) + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n_cycles(sz)));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_c(input string tag, input int sz);
        for (int n = 0; n < sz*sz; n++)
            chk($sformatf("%s_c%0d", tag, n), {32'd0, rdmem(sz, 2, n)}, {32'd0, mc_exp[n]});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr2"},  {62'd0, addr2}, 64'd0);
        chk({tag, "_data2"},  wdata2, 64'd0);
        chk({tag, "_ctl2"},   {58'd0, typ2, sel2, re2, we2}, 64'd0);
        chk({tag, "_stat2"},  {62'd0, busy2, done2}, 64'd0);
        chk({tag, "_addr3"},  {60'd0, addr3}, 64'd0);
        chk({tag, "_data3"},  wdata3[63:0], 64'd0);
        chk({tag, "_ctl3"},   {58'd0, typ3, sel3, re3, we3}, 64'd0);
        chk({tag, "_stat3"},  {62'd0, busy3, done3}, 64'd0);
    endtask

    initial begin
        int dc, bc, nc;

        rst_n  = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        hw2_en = 1'b0; hw2_idx = 0; hw2_data = '0;
        hw3_en = 1'b0; hw3_idx = 0; hw3_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // 1. Basic 2x2 product
        ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
        mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
        model(2);
        load(2);
        run(2, 0, 0, dc, bc, nc);
        check_run("t1", 2, dc, bc, nc);
        chk("t1_c00", {32'd0, rdmem(2, 2, 0)}, 64'd19);
        chk("t1_c01", {32'd0, rdmem(2, 2, 1)}, 64'd22);
        chk("t1_c10", {32'd0, rdmem(2, 2, 2)}, 64'd43);
        chk("t1_c11", {32'd0, rdmem(2, 2, 3)}, 64'd50);
        check_idle_outputs("t1_after");

        // 4. Start re-pulsed while busy: ignored, not queued
        load(2);
        run(2, 5, 22, dc, bc, nc);
        check_run("t4", 2, dc, bc, nc);
        check_c("t4", 2);

        // 3. Accumulator wraps modulo 2^32
        ma[0] = 32'hFFFF_FFFF; ma[1] = 0; ma[2] = 0; ma[3] = 0;
        mb[0] = 2; mb[1] = 0; mb[2] = 0; mb[3] = 0;
        model(2);
        load(2);
        run(2, 0, 0, dc, bc, nc);
        check_run("t3", 2, dc, bc, nc);
        chk("t3_wrap", {32'd0, rdmem(2, 2, 0)}, 64'h0000_0000_FFFF_FFFE);
        check_c("t3", 2);

        // 5. Reset in mid-run: outputs drop at once, written cells stay, next run is clean
        ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
        mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
        model(2);
        load(2);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t5_busy_before", {63'd0, busy2}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_c00_kept", {32'd0, rdmem(2, 2, 0)}, 64'd19);
        chk("t5_c01_unwritten", {32'd0, rdmem(2, 2, 1)}, {32'd0, SENT});
        chk("t5_c11_unwritten", {32'd0, rdmem(2, 2, 3)}, {32'd0, SENT});
        run(2, 0, 0, dc, bc, nc);
        check_run("t5_rerun", 2, dc, bc, nc);
        check_c("t5", 2);

        // 2. size 3: identity times B gives B; A and B untouched
        for (int n = 0; n < 9; n++) begin
            ma[n] = (n % 4 == 0) ? 32'd1 : 32'd0;
            mb[n] = 32'(n + 1);
        end
        model(3);
        load(3);
        run(3, 0, 0, dc, bc, nc);
        check_run("t2", 3, dc, bc, nc);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("t2_c%0d_eq_b", n), {32'd0, rdmem(3, 2, n)}, 64'(n + 1));
            chk($sformatf("t2_a%0d_kept", n), {32'd0, rdmem(3, 0, n)}, {32'd0, ma[n]});
            chk($sformatf("t2_b%0d_kept", n), {32'd0, rdmem(3, 1, n)}, {32'd0, mb[n]});
        end

        // Random matrices against the reference product
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 4; n++) begin ma[n] = $urandom; mb[n] = $urandom; end
            model(2);
            load(2);
            run(2, 0, 0, dc, bc, nc);
            check_run($sformatf("rnd2_%0d", r), 2, dc, bc, nc);
            check_c($sformatf("rnd2_%0d", r), 2);
        end
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 9; n++) begin ma[n] = $urandom; mb[n] = $urandom; end
            model(3);
            load(3);
            run(3, 0, 0, dc, bc, nc);
            check_run($sformatf("rnd3_%0d", r), 3, dc, bc, nc);
            check_c($sformatf("rnd3_%0d", r), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
